// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ character sources.
// Optional message lock (a winner keeps the transmitter until req_last) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*7-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [6:0]           tx_data,
  output logic                 tx_flush,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t               r_state;
  state_t               w_nextState;
  logic [6:0]           r_txData;
  logic                 r_txFlush;
  logic [ID_W-1:0]      r_grantId;
  logic [ID_W-1:0]      r_rrPtr;

  logic [NUM_REQ-1:0]   w_cand;
  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W:0]        w_idx;
  logic                 w_grant;
  logic                 w_advance;
  logic [ID_W-1:0]      w_ptrAfter;
  logic [NUM_REQ-1:0]   w_readyVec;

`ifdef UART_ARB_LOCK_EN
  logic                 r_lock;
  logic [ID_W-1:0]      r_owner;

  // While locked only the owner may win, even if it is currently idle.
  assign w_cand    = r_lock ? (req_valid & (NUM_REQ'(1) << r_owner)) : req_valid;
  assign w_advance = w_grant & req_last[w_winner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_grant) begin
      r_lock  <= ~req_last[w_winner];
      r_owner <= w_winner;
    end
  end
`else
  logic w_unusedLast;

  assign w_cand       = req_valid;
  assign w_advance    = w_grant;
  assign w_unusedLast = |req_last;
`endif

  // First candidate found scanning upward from rr_ptr with wrap-around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rrPtr} + (ID_W+1)'(i);
      if (w_idx >= NUM_REQ_W) w_idx = w_idx - NUM_REQ_W;
      if (!w_found && w_cand[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_grant    = (r_state == IDLE) && !tx_busy && w_found;
  assign w_ptrAfter = (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_readyVec  = '0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_readyVec[w_winner] = 1'b1;
          w_nextState          = ISSUE;
        end
      end
      ISSUE:     w_nextState = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  w_nextState = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Flush is raised only on the handshake edge so it lasts exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txData  <= '0;
      r_txFlush <= 1'b0;
      r_grantId <= '0;
      r_rrPtr   <= '0;
    end else begin
      r_txFlush <= w_grant;
      if (w_grant) begin
        r_txData  <= req_data[int'(w_winner)*7 +: 7];
        r_grantId <= w_winner;
      end
      if (w_advance) r_rrPtr <= w_ptrAfter;
    end
  end

  assign req_ready = w_readyVec;
  assign tx_data   = r_txData;
  assign tx_flush  = r_txFlush;
  assign grant_id  = r_grantId;
  assign active    = (r_state != IDLE);

endmodule
